csa_pipe_adder: RTL and testbench

//  Parametrised, pipelined carry-select adder/subtractor; successor to the fixed 8-bit CSA_8.

---
 rtl/csa_pkg.sv | 17 +
 rtl/csa_segment.sv | 52 +++++
 rtl/csa_pipe_adder.sv | 126 ++++++++++++
 tb/tb_csa_pipe_adder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared constants and elaboration helpers for the pipelined carry-select adder
package csa_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int seg_w(input int width, input int stages);
        return (stages > 0) ? width / stages : width;
    endfunction

    // Segments must split evenly into whole carry-select blocks
    function automatic bit cfg_ok(input int width, input int block, input int stages);
        return (stages >= 1) && (block >= 1) && (width >= 1) &&
               ((width % (stages * block)) == 0);
    endfunction

endpackage

// File: rtl/csa_segment.sv
// rtl/csa_segment.sv - combinational carry-select adder for one pipeline segment (c_msb only with CSA_OVERFLOW_EN)
module csa_segment #(
    parameter int SEG_W = 16,
    parameter int BLOCK = 4
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout
`ifdef CSA_OVERFLOW_EN
    ,
    output logic             c_msb
`endif
);

    localparam int NB = SEG_W / BLOCK;

    logic [NB:0] c;

    assign c[0] = cin;

    for (genvar j = 0; j < NB; j++) begin : g_blk
        logic [BLOCK-1:0] ab;
        logic [BLOCK-1:0] bb;

        assign ab = a[j*BLOCK +: BLOCK];
        assign bb = b[j*BLOCK +: BLOCK];

        if (j == 0) begin : g_direct
            logic [BLOCK:0] s;
            assign s = {1'b0, ab} + {1'b0, bb} + {{BLOCK{1'b0}}, c[0]};
            assign sum[j*BLOCK +: BLOCK] = s[BLOCK-1:0];
            assign c[j+1] = s[BLOCK];
        end else begin : g_select
            // Both carry hypotheses are ready before the block carry arrives
            logic [BLOCK:0] s0;
            logic [BLOCK:0] s1;
            assign s0 = {1'b0, ab} + {1'b0, bb};
            assign s1 = {1'b0, ab} + {1'b0, bb} + {{BLOCK{1'b0}}, 1'b1};
            assign sum[j*BLOCK +: BLOCK] = c[j] ? s1[BLOCK-1:0] : s0[BLOCK-1:0];
            assign c[j+1] = c[j] ? s1[BLOCK] : s0[BLOCK];
        end
    end

    assign cout = c[NB];

`ifdef CSA_OVERFLOW_EN
    assign c_msb = a[SEG_W-1] ^ b[SEG_W-1] ^ sum[SEG_W-1];
`endif

endmodule

// File: rtl/csa_pipe_adder.sv
// rtl/csa_pipe_adder.sv - pipelined carry-select adder/subtractor, one segment per stage; CSA_OVERFLOW_EN adds ovf
module csa_pipe_adder
    import csa_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CSA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int SEG = seg_w(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, BLOCK, STAGES)) begin : g_cfg_err
        $error("csa_pipe_adder: WIDTH must be a multiple of STAGES*BLOCK and STAGES >= 1");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;

    logic             v_i [STAGES];
    logic             c_i [STAGES];
    logic [WIDTH-1:0] a_i [STAGES];
    logic [WIDTH-1:0] b_i [STAGES];
    logic [WIDTH-1:0] s_i [STAGES];

    logic             v_q [STAGES];
    logic             c_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];

    logic [SEG-1:0]   seg_sum [STAGES];
    logic             seg_c   [STAGES];
`ifdef CSA_OVERFLOW_EN
    logic             seg_cm  [STAGES];
    logic             ovf_q;
`endif

    // Whole pipeline moves as one; a full stall freezes every stage including bubbles
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Subtraction folds into the add by inverting b once at entry; later stages never see sub
    assign b_eff = (sub == OP_SUB) ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign v_i[k] = in_valid;
            assign c_i[k] = cin;
            assign a_i[k] = a;
            assign b_i[k] = b_eff;
            assign s_i[k] = '0;
        end else begin : g_link
            assign v_i[k] = v_q[k-1];
            assign c_i[k] = c_q[k-1];
            assign a_i[k] = a_q[k-1];
            assign b_i[k] = b_q[k-1];
            assign s_i[k] = s_q[k-1];
        end

        csa_segment #(
            .SEG_W (SEG),
            .BLOCK (BLOCK)
        ) u_seg (
            .a     (a_i[k][k*SEG +: SEG]),
            .b     (b_i[k][k*SEG +: SEG]),
            .cin   (c_i[k]),
            .sum   (seg_sum[k]),
            .cout  (seg_c[k])
`ifdef CSA_OVERFLOW_EN
            ,
            .c_msb (seg_cm[k])
`endif
        );

        always_ff @(posedge clock) begin
            if (reset) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end else if (adv) begin
                v_q[k] <= v_i[k];
                c_q[k] <= seg_c[k];
                a_q[k] <= a_i[k];
                b_q[k] <= b_i[k];
                s_q[k] <= s_i[k];
                s_q[k][k*SEG +: SEG] <= seg_sum[k];
            end
        end
    end

`ifdef CSA_OVERFLOW_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= seg_cm[STAGES-1] ^ seg_c[STAGES-1];
        end
    end

    assign ovf = ovf_q;
`endif

    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];

endmodule

// File: tb/tb_csa_pipe_adder.sv
// tb/tb_csa_pipe_adder.sv - scoreboard bench for csa_pipe_adder at WIDTH=8, STAGES=2, BLOCK=2 (ovf checked with CSA_OVERFLOW_EN)
module tb_csa_pipe_adder;

    localparam int W  = 8;
    localparam int ST = 2;
    localparam int BL = 2;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef CSA_OVERFLOW_EN
    logic         ovf;
`endif

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t scb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_chk  = 0;
    bit   mon_en = 1'b0;
    bit   bp_stop = 1'b0;

    csa_pipe_adder #(
        .WIDTH  (W),
        .BLOCK  (BL),
        .STAGES (ST)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CSA_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clock = ~clock;

    // Reference: plain integer arithmetic on the operand values
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic s);
        exp_t e;
        int   ux, uy, full, sx, sy, sres;
        ux   = int'(x);
        uy   = s ? ((2 ** W) - 1 - int'(y)) : int'(y);
        full = ux + uy + int'(ci);
        e.sum  = W'(full % (2 ** W));
        e.cout = (full >= (2 ** W));
        sx   = int'($signed(x));
        sy   = s ? (-int'($signed(y)) - 1) : int'($signed(y));
        sres = sx + sy + int'(ci);
        e.ovf  = (sres > (2 ** (W - 1)) - 1) || (sres < -(2 ** (W - 1)));
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        n_miss++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Monitor: compare every presented result; pop only on transfer
    initial begin
        forever begin
            @(negedge clock);
            if (mon_en && out_valid) begin
                if (scb.size() == 0) begin
                    chk("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    chk("sum", 32'(sum), 32'(scb[0].sum));
                    chk("cout", 32'(cout), 32'(scb[0].cout));
`ifdef CSA_OVERFLOW_EN
                    chk("ovf", 32'(ovf), 32'(scb[0].ovf));
`endif
                    if (out_ready) void'(scb.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic s);
        int waited;
        bit done;
        waited = 0;
        done = 1'b0;
        a = x;
        b = y;
        cin = ci;
        sub = s;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clock);
            if (in_ready) begin
                scb.push_back(model(x, y, ci, s));
                n_vec++;
                @(posedge clock);
                #1;
                done = 1'b1;
            end else if (waited > 200) begin
                timeout_fail("send_timeout");
                in_valid = 1'b0;
                done = 1'b1;
            end
            waited++;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (scb.size() != 0 && n < 100) begin
            @(posedge clock);
            n++;
        end
        if (scb.size() != 0) timeout_fail("drain_timeout");
        #1;
    endtask

    // One beat into an empty pipe with out_ready=1: result appears exactly ST cycles later
    task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                            input logic s, input logic [W-1:0] es, input logic ec,
                            input logic eo);
        send(x, y, ci, s);
        in_valid = 1'b0;
        @(negedge clock);
        chk("latency_early", 32'(out_valid), 32'd0);
        @(negedge clock);
        chk("latency_valid", 32'(out_valid), 32'd1);
        chk("dir_sum", 32'(sum), 32'(es));
        chk("dir_cout", 32'(cout), 32'(ec));
`ifdef CSA_OVERFLOW_EN
        chk("dir_ovf", 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) chk("dir_ovf_arg", 32'(eo), 32'd0);
`endif
        @(posedge clock);
        #1;
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] corners [6];
        corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF};
        if ($urandom_range(3) == 0) return corners[$urandom_range(5)];
        return W'($urandom);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        in_valid = 1'b1;
        a = 8'hA5;
        b = 8'h5A;
        cin = 1'b1;
        sub = 1'b0;
        out_ready = 1'b1;

        repeat (2) begin
            @(posedge clock);
            @(negedge clock);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_sum", 32'(sum), 32'd0);
            chk("rst_cout", 32'(cout), 32'd0);
        end
        reset = 1'b0;
        in_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_sum", 32'(sum), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        mon_en = 1'b1;

        directed(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        directed(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        directed(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        directed(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        directed(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Stream 1..10 with a 3-cycle output stall in the middle
        fork
            begin
                for (int i = 1; i <= 10; i++) send(W'(i), 8'h00, 1'b0, 1'b0);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clock);
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clock);
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                    @(posedge clock);
                end
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Random traffic with random backpressure and input gaps
        bp_stop = 1'b0;
        fork
            begin
                while (!bp_stop) begin
                    @(posedge clock);
                    #1;
                    if (!bp_stop) out_ready = ($urandom_range(3) != 0);
                end
            end
            begin
                for (int i = 0; i < 2000; i++) begin
                    if ($urandom_range(7) == 0) idle();
                    else send(pick(), pick(), 1'($urandom_range(1)), 1'($urandom_range(1)));
                end
                in_valid = 1'b0;
                bp_stop = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset with beats in flight: they must never appear
        out_ready = 1'b0;
        send(8'h11, 8'h22, 1'b0, 1'b0);
        send(8'h33, 8'h44, 1'b1, 1'b1);
        in_valid = 1'b0;
        mon_en = 1'b0;
        reset = 1'b1;
        scb.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        mon_en = 1'b1;
        repeat (4) begin
            @(negedge clock);
            chk("flush_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clock);
        #1;
        directed(8'hC3, 8'h3D, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
